// File: rtl/axis_fifo_rr_arbiter.sv
// axis_fifo_rr_arbiter
//   Round-robin arbiter that drains C_NUM_SRC standard-mode FIFOs onto a single
//   AXI4-Stream master. Each grant becomes one packet of at most C_MAX_BURST beats.
//   A packet also ends early when the granted FIFO runs dry.
//
// Ports
//   M_AXIS_ACLK    clock; all logic runs on its rising edge
//   M_AXIS_ARESET  synchronous, active-high reset
//   M_AXIS_TVALID  output beat valid (state SEND)
//   M_AXIS_TDATA   output payload, taken from the FIFO slice of the granted source
//   M_AXIS_TLAST   last beat of the current grant
//   M_AXIS_TID     granted source index while sending, 0 otherwise
//   M_AXIS_TREADY  downstream accept
//   fifo_dout      concatenated FIFO read data; source i occupies slice i
//   fifo_empty     per-source empty flags
//   fifo_rd_en     per-source read strobes (one-hot, one cycle per beat)
//   src_enable     per-source arbitration eligibility mask
//   busy           high whenever the FSM is not idle
module axis_fifo_rr_arbiter #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_NUM_SRC            = 4,
  parameter int C_MAX_BURST          = 16
) (
  input  logic                                      M_AXIS_ACLK,
  input  logic                                      M_AXIS_ARESET,
  output logic                                      M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                                      M_AXIS_TLAST,
  output logic [2:0]                                M_AXIS_TID,
  input  logic                                      M_AXIS_TREADY,
  input  logic [C_NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] fifo_dout,
  input  logic [C_NUM_SRC-1:0]                      fifo_empty,
  output logic [C_NUM_SRC-1:0]                      fifo_rd_en,
  input  logic [C_NUM_SRC-1:0]                      src_enable,
  output logic                                      busy
);

  localparam int unsigned NSRC = C_NUM_SRC;
  localparam int unsigned DW   = C_M_AXIS_TDATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    READ = 3'b010,
    SEND = 3'b100
  } state_t;

  state_t     state;
  logic [2:0] grant;
  logic [2:0] last_grant;
  logic [7:0] beat_cnt;
  logic       send_first;  // first SEND cycle of the current beat
  logic       tlast_q;     // TLAST captured in that first cycle

  // Flags widened to 8 bits so a 3-bit source index can select them directly.
  logic [7:0] empty8;
  logic [7:0] elig8;

  always_comb begin
    empty8 = '0;
    elig8  = '0;
    empty8[C_NUM_SRC-1:0] = fifo_empty;
    elig8[C_NUM_SRC-1:0]  = ~fifo_empty & src_enable;
  end

  // First eligible source searching upward from base+1, wrapping. Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [2:0] base, input logic [7:0] elig);
    logic        found;
    logic [2:0]  idx;
    int unsigned s;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      s = 32'(base) + k;
      if (s >= NSRC) s = s - NSRC;
      if (!found && elig[3'(s)]) begin
        found = 1'b1;
        idx   = 3'(s);
      end
    end
    return {found, idx};
  endfunction

  logic [3:0] pick_idle;   // arbitration against the stored last_grant
  logic [3:0] pick_send;   // arbitration as if last_grant were already the current grant
  logic       tlast_cand;
  logic       tlast_now;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] data_sel;

  always_comb begin
    pick_idle  = rr_pick(last_grant, elig8);
    pick_send  = rr_pick(grant, elig8);
    // The FIFO flag already reflects the read issued in READ, so empty here
    // means the beat being presented is the final word held by that source.
    tlast_cand = (beat_cnt == 8'(C_MAX_BURST)) || empty8[grant];
    // The candidate is only trusted in the first SEND cycle; later writes into
    // the FIFO during a stall must not retract TLAST.
    tlast_now  = send_first ? tlast_cand : tlast_q;
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (grant == 3'(i)) data_sel = fifo_dout[i*DW +: DW];
    end
  end

  always_comb begin
    M_AXIS_TVALID = (state == SEND);
    M_AXIS_TDATA  = (state == SEND) ? data_sel : '0;
    M_AXIS_TLAST  = (state == SEND) ? tlast_now : 1'b0;
    M_AXIS_TID    = (state == SEND) ? grant : 3'd0;
    busy          = (state != IDLE);
    fifo_rd_en    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      fifo_rd_en[i] = (state == READ) && (grant == 3'(i));
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state      <= IDLE;
      grant      <= '0;
      beat_cnt   <= '0;
      last_grant <= 3'(C_NUM_SRC - 1);
      tlast_q    <= 1'b0;
      send_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[3]) begin
            grant    <= pick_idle[2:0];
            beat_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          beat_cnt   <= beat_cnt + 8'd1;
          send_first <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          send_first <= 1'b0;
          if (send_first) tlast_q <= tlast_cand;
          if (M_AXIS_TREADY) begin
            if (tlast_now) begin
              last_grant <= grant;
              if (pick_send[3]) begin
                grant    <= pick_send[2:0];
                beat_cnt <= '0;
                state    <= READ;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
module tb_axis_fifo_rr_arbiter;

  localparam int W  = 32;
  localparam int NS = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tvalid;
  logic [W-1:0]    tdata;
  logic            tlast;
  logic [2:0]      tid;
  logic            tready = 1'b1;
  logic [NS*W-1:0] fifo_dout;
  logic [NS-1:0]   fifo_empty = '1;
  logic [NS-1:0]   fifo_rd_en;
  logic [NS-1:0]   src_enable = '1;
  logic            busy;

  always #5 clk = ~clk;

  axis_fifo_rr_arbiter #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .C_NUM_SRC(NS),
    .C_MAX_BURST(MB)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(rst),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TID(tid),
    .M_AXIS_TREADY(tready),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .src_enable(src_enable),
    .busy(busy)
  );

  typedef struct packed {
    logic [2:0]   tid;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } wr_t;

  beat_t        exp_q[$];
  wr_t          wr_q[$];
  logic [W-1:0] fq [NS][$];
  logic [W-1:0] dout_r [NS] = '{default: '0};
  int unsigned  rd_cnt [NS] = '{default: 0};
  int           n_tests = 0;
  int           n_fail  = 0;

  always_comb begin
    for (int i = 0; i < NS; i++) fifo_dout[i*W +: W] = dout_r[i];
  end

  // Standard-mode FIFO model: data appears the cycle after the read strobe,
  // writes queued by the stimulus land on the next rising edge.
  always @(posedge clk) begin
    logic [NS-1:0] e;
    wr_t w;
    for (int i = 0; i < NS; i++) begin
      if (fifo_rd_en[i]) begin
        rd_cnt[i]++;
        n_tests++;
        if (fq[i].size() == 0) begin
          n_fail++;
          $display("FAIL rd_on_empty: src %0d got read strobe, required none", i);
        end else begin
          dout_r[i] <= fq[i].pop_front();
        end
      end
    end
    while (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      fq[w.src].push_back(w.data);
    end
    for (int i = 0; i < NS; i++) e[i] = (fq[i].size() == 0);
    fifo_empty <= e;
  end

  // Scoreboard monitor: every accepted beat is compared with the oldest expectation.
  always @(negedge clk) begin
    beat_t g, r;
    if (!rst && tvalid && tready) begin
      g.tid = tid; g.data = tdata; g.last = tlast;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got tid=%0d data=%h last=%0d, required no beat", tid, tdata, tlast);
      end else begin
        r = exp_q.pop_front();
        if (g !== r) begin
          n_fail++;
          $display("FAIL beat: got tid=%0d data=%h last=%0d, required tid=%0d data=%h last=%0d",
                   g.tid, g.data, g.last, r.tid, r.data, r.last);
        end
      end
    end
  end

  function automatic logic [W-1:0] mkd(input int s, input int n);
    return 32'hD000_0000 | (32'(s) << 8) | 32'(n);
  endfunction

  task automatic push(input int s, input int n);
    wr_t w;
    w.src  = 2'(s);
    w.data = mkd(s, n);
    wr_q.push_back(w);
  endtask

  task automatic expect_beat(input int s, input int n, input logic l);
    beat_t b;
    b.tid = 3'(s); b.data = mkd(s, n); b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    check({tag, "_tlast"},  32'(tlast),  32'd0);
    check({tag, "_tid"},    32'(tid),    32'd0);
    check({tag, "_rd_en"},  32'(fifo_rd_en), 32'd0);
    check({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(posedge clk); #1 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle(tag);
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (!(exp_q.size() == 0 && wr_q.size() == 0 && !busy) && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (c >= 300) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d beats outstanding, required 0", tag, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!tvalid && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (c >= 50) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: got tvalid=0, required 1", tag);
    end
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got no completion, required finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int c;

    // Two 3-word sources, free-flowing sink.
    do_reset(3, "rst0");
    for (int n = 0; n < 3; n++) begin push(0, n); push(2, n); end
    for (int n = 0; n < 3; n++) expect_beat(0, n, n == 2);
    for (int n = 0; n < 3; n++) expect_beat(2, n, n == 2);
    wait_drain("two_src");

    // Burst cap of 4 interleaved with a short source.
    do_reset(1, "rst1");
    for (int n = 0; n < 10; n++) push(1, n);
    push(3, 0); push(3, 1);
    for (int n = 0; n < 4; n++)  expect_beat(1, n, n == 3);
    expect_beat(3, 0, 1'b0); expect_beat(3, 1, 1'b1);
    for (int n = 4; n < 8; n++)  expect_beat(1, n, n == 7);
    expect_beat(1, 8, 1'b0); expect_beat(1, 9, 1'b1);
    wait_drain("burst");

    // Single beat stalled by the sink while the FIFO is refilled.
    do_reset(1, "rst2");
    tready = 1'b0;
    push(0, 0);
    expect_beat(0, 0, 1'b1);
    c = 0;
    while (fifo_empty[0] && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    check("lat_read_tvalid", 32'(tvalid), 32'd0);
    check("lat_read_rd_en", 32'(fifo_rd_en), 32'h1);
    @(negedge clk);
    check("lat_send_tvalid", 32'(tvalid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin push(0, 1); expect_beat(0, 1, 1'b1); end
      @(negedge clk);
      check("stall_tvalid", 32'(tvalid), 32'd1);
      check("stall_tdata", tdata, mkd(0, 0));
      check("stall_tlast", 32'(tlast), 32'd1);
    end
    @(posedge clk); #1 tready = 1'b1;
    wait_drain("stall");

    // All four sources with one word each, then source 0 again.
    do_reset(1, "rst3");
    for (int s = 0; s < NS; s++) begin push(s, 0); expect_beat(s, 0, 1'b1); end
    wait_drain("rr4");
    push(0, 1); expect_beat(0, 1, 1'b1);
    wait_drain("rr4_again");

    // Masked source 0 stays unread until re-enabled.
    do_reset(1, "rst4");
    src_enable = 4'b1110;
    base = rd_cnt[0];
    push(0, 0); push(2, 0);
    expect_beat(2, 0, 1'b1);
    wait_drain("mask");
    repeat (10) @(negedge clk);
    check("mask_src0_reads", rd_cnt[0] - base, 32'd0);
    check("mask_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 src_enable = 4'b1111;
    expect_beat(0, 0, 1'b1);
    wait_drain("unmask");
    check("unmask_src0_reads", rd_cnt[0] - base, 32'd1);

    // Reset while a beat sits in SEND.
    do_reset(1, "rst5");
    tready = 1'b0;
    base = rd_cnt[0];
    push(0, 0); push(0, 1); push(0, 2); push(1, 0);
    wait_valid("rst_mid");
    check("rst_mid_tid", 32'(tid), 32'd0);
    check("rst_mid_tdata", tdata, mkd(0, 0));
    do_reset(1, "rst_mid_after");
    check("rst_mid_reads", rd_cnt[0] - base, 32'd1);
    tready = 1'b1;
    expect_beat(0, 1, 1'b0); expect_beat(0, 2, 1'b1); expect_beat(1, 0, 1'b1);
    wait_drain("post_rst");
    check("post_rst_reads", rd_cnt[0] - base, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_fifo_rr_arbiter.md
AXIS_FIFO_RR_ARBITER -- requirements
Module: axis_fifo_rr_arbiter

Interface
REQ-001 The block SHALL use parameter C_M_AXIS_TDATA_WIDTH, default 32, as the stream and FIFO data width.
REQ-002 The block SHALL use parameter C_NUM_SRC, default 4, legal 2..8, as the number of source FIFOs.
REQ-003 The block SHALL use parameter C_MAX_BURST, default 16, legal 1..255, as the maximum beats per grant.
REQ-004 The block SHALL have port M_AXIS_ACLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port M_AXIS_ARESET  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port M_AXIS_TVALID  out  1  the output beat is valid.
REQ-007 The block SHALL have port M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  the output payload.
REQ-008 The block SHALL have port M_AXIS_TLAST  out  1  the last beat of a grant (packet).
REQ-009 The block SHALL have port M_AXIS_TID  out  3  the index of the granted source, zero-extended.
REQ-010 The block SHALL have port M_AXIS_TREADY  in  1  the downstream sink accepts a beat.
REQ-011 The block SHALL have port fifo_dout  in  C_NUM_SRC*C_M_AXIS_TDATA_WIDTH  the concatenated FIFO outputs; source i occupies slice i.
REQ-012 The block SHALL have port fifo_empty  in  C_NUM_SRC  the per-source empty flags.
REQ-013 The block SHALL have port fifo_rd_en  out  C_NUM_SRC  the per-source read strobes.
REQ-014 The block SHALL have port src_enable  in  C_NUM_SRC  the per-source arbitration eligibility mask.
REQ-015 The block SHALL have port busy  out  1  high when the state is not IDLE.

Function
REQ-016 The block SHALL treat the source FIFOs as standard-mode: fifo_dout is valid in the cycle after a cycle in which fifo_rd_en is high, and it stays valid until the next read.
REQ-017 The block SHALL implement the states IDLE, READ and SEND in a one-hot encoding; any illegal encoding SHALL return to IDLE.
REQ-018 A source SHALL be eligible when fifo_empty[i]=0 and src_enable[i]=1.
REQ-019 The round-robin winner SHALL be the first eligible source searching upward from last_grant+1, wrapping modulo C_NUM_SRC.
REQ-020 IDLE: outputs are inactive; if any source is eligible, grant <= winner, beat_cnt <= 0 and the next state is READ; otherwise the block stays in IDLE.
REQ-021 READ: the block SHALL assert exactly one cycle of fifo_rd_en[grant]=1, with all other bits 0, and set beat_cnt <= beat_cnt+1; the next state is SEND.
REQ-022 SEND: the block SHALL drive M_AXIS_TVALID=1 and M_AXIS_TDATA = slice grant of fifo_dout, combinationally; fifo_rd_en SHALL be all 0.
REQ-023 The TLAST candidate SHALL be (beat_cnt == C_MAX_BURST) OR fifo_empty[grant], evaluated in the first SEND cycle of each beat.
REQ-024 The block SHALL register the candidate and hold M_AXIS_TLAST stable until the handshake, even if fifo_empty[grant] changes while M_AXIS_TREADY=0.
REQ-025 M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TID SHALL be stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-026 A handshake with TLAST=0 SHALL keep the same grant and go to READ; the source is non-empty by construction.
REQ-027 A handshake with TLAST=1 SHALL set last_grant <= grant; if any source is eligible, evaluated with the new last_grant, the block SHALL load the new grant and go directly to READ; otherwise it SHALL go to IDLE.
REQ-028 Latency from non-empty to TVALID SHALL be 2 cycles from IDLE: IDLE -> READ -> SEND. The gap between back-to-back beats SHALL be 1 cycle (READ).
REQ-029 Deasserting src_enable[grant] mid-grant SHALL NOT abort the packet; the mask affects only the next arbitration.
REQ-030 M_AXIS_TID SHALL equal grant while the state is SEND, and 0 otherwise.
REQ-031 The block SHALL never assert fifo_rd_en for a source whose fifo_empty=1 in that cycle.

Reset
REQ-032 While M_AXIS_ARESET=1 at a clock edge: state <= IDLE, grant <= 0, beat_cnt <= 0, last_grant <= C_NUM_SRC-1 (so source 0 has first priority) and the held TLAST <= 0.
REQ-033 During and immediately after reset, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TID=0, fifo_rd_en=0 and busy=0.
REQ-034 Reset asserted mid-packet SHALL abandon the beat without issuing a read; the first post-reset grant SHALL start a new packet.

Verification
REQ-035 The bench SHALL cover: sources 0 and 2 each hold 3 words, TREADY=1 -> a packet of 3 beats with TID=0, then 3 beats with TID=2; TLAST is on beats 3 and 6.
REQ-036 The bench SHALL cover: C_MAX_BURST=4, source 1 holds 10 words, source 3 holds 2, TREADY=1 -> packets with TID=1 (4 beats), then TID=3 (2), then TID=1 (4), then TID=1 (2).
REQ-037 The bench SHALL cover: a single beat pending, TREADY held at 0 for 5 cycles with a FIFO write during the stall -> TVALID, TDATA and TLAST=1 held unchanged, then accepted on the first TREADY=1 cycle.
REQ-038 The bench SHALL cover: all 4 sources non-empty, each holding 1 word -> grant order 0,1,2,3; a new word in source 0 after that -> TID=0 next.
REQ-039 The bench SHALL cover: src_enable=4'b1110 with source 0 non-empty -> source 0 is never read; setting bit 0 high -> source 0 is served on the next arbitration.
REQ-040 The bench SHALL cover: reset pulsed during SEND -> TVALID=0 in the next cycle, no extra fifo_rd_en, and the next grant goes to source 0 if it is eligible.
